// File: rtl/ym3812_regs.sv
// ym3812_regs: OPL2 CPU register front end (index/data ports, channel write strobes, operator fields).
// Define YM3812_TIMERS_EN to build the two timers, status byte and irq; otherwise status reads 0x00.
module ym3812_regs #(
  parameter int CLK_HZ = 75000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_a0,
  input  logic [7:0]  io_din,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [7:0]  io_dout,
  output logic [7:0]  din,
  output logic [8:0]  wr_an,
  output logic [8:0]  wr_bn,
  output logic [71:0] harmonic,
  output logic [35:0] waveform,
  output logic        irq
);
  localparam int T1_PERIOD = CLK_HZ / 12500;

  logic [7:0]  index;
  logic        wse;
  logic [71:0] mult_q;
  logic [35:0] wave_q;

  logic       wr_index, wr_data;
  logic [4:0] op_off;
  logic [1:0] op_g;
  logic [2:0] op_s;
  logic [4:0] op_k;
  logic       op_ok, sel_a, sel_b, sel_mult, sel_wave;
  logic       unused_rd;

  // Status reads have no side effects, so the read strobe is not needed.
  assign unused_rd = io_rd;

  assign wr_index = io_wr & ~io_a0;
  assign wr_data  = io_wr & io_a0;

  // Operator offset o = 8*g + s maps to operator 6*g + s; s = 6,7 and g = 3 are holes.
  assign op_off = index[4:0];
  assign op_g   = op_off[4:3];
  assign op_s   = op_off[2:0];
  assign op_ok  = (op_g != 2'd3) && (op_s < 3'd6);
  assign op_k   = 5'(op_g) * 5'd6 + 5'(op_s);

  assign sel_a    = wr_data && (index >= 8'hA0) && (index <= 8'hA8);
  assign sel_b    = wr_data && (index >= 8'hB0) && (index <= 8'hB8);
  assign sel_mult = wr_data && (index[7:5] == 3'b001) && op_ok;
  assign sel_wave = wr_data && (index[7:5] == 3'b111) && op_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      index  <= '0;
      din    <= '0;
      wr_an  <= '0;
      wr_bn  <= '0;
      wse    <= 1'b0;
      mult_q <= '0;
      wave_q <= '0;
    end else begin
      wr_an <= '0;
      wr_bn <= '0;
      if (wr_index) index <= io_din;
      if (sel_a) begin
        din   <= io_din;
        wr_an <= 9'd1 << index[3:0];
      end
      if (sel_b) begin
        din   <= io_din;
        wr_bn <= 9'd1 << index[3:0];
      end
      if (wr_data && (index == 8'h01)) wse <= io_din[5];
      if (sel_mult) mult_q[{op_k, 2'b00} +: 4] <= io_din[3:0];
      if (sel_wave) wave_q[{op_k, 1'b0} +: 2] <= io_din[1:0];
    end
  end

  assign harmonic = mult_q;
  // Stored waveforms survive WSE=0; only the output is forced to sine.
  assign waveform = wse ? wave_q : '0;

`ifdef YM3812_TIMERS_EN
  localparam int PRE_W = $clog2(T1_PERIOD + 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [1:0]       t2_div;
  logic             t1_tick, t2_tick, ctl_wr, ctl_clr, ctl_set;
  logic [7:0]       pre1, pre2, cnt1, cnt2;
  logic             run1, run2, mask1, mask2, flag1, flag2;

  assign t1_tick = (pre_cnt == '0);
  assign t2_tick = t1_tick && (t2_div == 2'd0);
  assign ctl_wr  = wr_data && (index == 8'h04);
  assign ctl_clr = ctl_wr && io_din[7];
  assign ctl_set = ctl_wr && !io_din[7];

  // Free-running 80 us prescaler; T2 ticks on every fourth T1 tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= PRE_W'(T1_PERIOD - 1);
      t2_div  <= 2'd3;
    end else if (t1_tick) begin
      pre_cnt <= PRE_W'(T1_PERIOD - 1);
      t2_div  <= t2_div - 2'd1;
    end else begin
      pre_cnt <= pre_cnt - PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre1  <= '0;
      pre2  <= '0;
      cnt1  <= '0;
      cnt2  <= '0;
      run1  <= 1'b0;
      run2  <= 1'b0;
      mask1 <= 1'b0;
      mask2 <= 1'b0;
      flag1 <= 1'b0;
      flag2 <= 1'b0;
    end else begin
      if (wr_data && (index == 8'h02)) pre1 <= io_din;
      if (wr_data && (index == 8'h03)) pre2 <= io_din;
      if (ctl_set) begin
        mask1 <= io_din[6];
        mask2 <= io_din[5];
        run1  <= io_din[0];
        run2  <= io_din[1];
      end

      if (ctl_set && io_din[0] && !run1) cnt1 <= pre1;
      else if (run1 && t1_tick) cnt1 <= (cnt1 == 8'hFF) ? pre1 : cnt1 + 8'd1;
      if (ctl_set && io_din[1] && !run2) cnt2 <= pre2;
      else if (run2 && t2_tick) cnt2 <= (cnt2 == 8'hFF) ? pre2 : cnt2 + 8'd1;

      // A clear in the same cycle as an overflow wins; that overflow is lost.
      if (ctl_clr) flag1 <= 1'b0;
      else if (run1 && t1_tick && (cnt1 == 8'hFF) && !mask1) flag1 <= 1'b1;
      if (ctl_clr) flag2 <= 1'b0;
      else if (run2 && t2_tick && (cnt2 == 8'hFF) && !mask2) flag2 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) io_dout <= '0;
    else     io_dout <= {flag1 | flag2, flag1, flag2, 5'b0};
  end

  assign irq = flag1 | flag2;
`else
  logic [31:0] unused_period;
  assign unused_period = T1_PERIOD;
  assign io_dout = 8'h00;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_ym3812_regs.sv
// tb_ym3812_regs: random register traffic against a behavioural register model,
// plus directed strobe, WSE, reset and timer/status scenarios.
module tb_ym3812_regs;
  localparam int CLK_HZ = 75000000;
  localparam int T1_PER = CLK_HZ / 12500;
  localparam int T2_PER = 4 * T1_PER;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_a0 = 1'b0;
  logic [7:0]  io_din = 8'h00;
  logic        io_wr = 1'b0;
  logic        io_rd = 1'b0;
  logic [7:0]  io_dout;
  logic [7:0]  din;
  logic [8:0]  wr_an;
  logic [8:0]  wr_bn;
  logic [71:0] harmonic;
  logic [35:0] waveform;
  logic        irq;

  ym3812_regs #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .io_a0(io_a0), .io_din(io_din), .io_wr(io_wr), .io_rd(io_rd),
    .io_dout(io_dout), .din(din), .wr_an(wr_an), .wr_bn(wr_bn),
    .harmonic(harmonic), .waveform(waveform), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int mult_m[18];
  int wave_m[18];
  int wse_m;
  int din_m;

  task automatic chk_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 18; k++) begin
      mult_m[k] = 0;
      wave_m[k] = 0;
    end
    wse_m = 0;
    din_m = 0;
  endtask

  function automatic int op_of(input int idx);
    int o, g, s;
    o = idx % 32;
    g = o / 8;
    s = o % 8;
    if (g > 2 || s > 5) return -1;
    return 6 * g + s;
  endfunction

  task automatic model_write(input int idx, input int d);
    if ((idx >= 'hA0 && idx <= 'hA8) || (idx >= 'hB0 && idx <= 'hB8)) din_m = d;
    if (idx >= 'h20 && idx <= 'h35 && op_of(idx) >= 0) mult_m[op_of(idx)] = d % 16;
    if (idx >= 'hE0 && idx <= 'hF5 && op_of(idx) >= 0) wave_m[op_of(idx)] = d % 4;
    if (idx == 1) wse_m = (d / 32) % 2;
  endtask

  function automatic logic [71:0] exp_harm();
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 18; k++) v[4*k +: 4] = 4'(mult_m[k]);
    return v;
  endfunction

  function automatic logic [35:0] exp_wave();
    logic [35:0] v;
    v = '0;
    if (wse_m != 0)
      for (int k = 0; k < 18; k++) v[2*k +: 2] = 2'(wave_m[k]);
    return v;
  endfunction

  // Called at a negedge; returns at the negedge where the write's results are visible.
  task automatic bus_wr(input logic a0, input logic [7:0] d);
    io_a0  = a0;
    io_din = d;
    io_wr  = 1'b1;
    @(negedge clk);
    io_wr  = 1'b0;
  endtask

  task automatic reg_wr(input logic [7:0] idx, input logic [7:0] d);
    bus_wr(1'b0, idx);
    bus_wr(1'b1, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wr_and_check(input int idx, input int d,
                              output logic [8:0] an, output logic [8:0] bn, output logic [7:0] dd);
    logic [8:0] ea, eb;
    reg_wr(8'(idx), 8'(d));
    model_write(idx, d);
    ea = (idx >= 'hA0 && idx <= 'hA8) ? 9'(1 << (idx - 'hA0)) : 9'h000;
    eb = (idx >= 'hB0 && idx <= 'hB8) ? 9'(1 << (idx - 'hB0)) : 9'h000;
    an = wr_an;
    bn = wr_bn;
    dd = din;
    chk_val("wr_an", wr_an, ea);
    chk_val("wr_bn", wr_bn, eb);
    chk_val("din", din, din_m);
    chk_val("harmonic", harmonic, exp_harm());
    chk_val("waveform", waveform, exp_wave());
    @(negedge clk);
    chk_val("wr_an_one_cycle", wr_an, 0);
    chk_val("wr_bn_one_cycle", wr_bn, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] an, bn;
    logic [7:0] dd;
    int idx, d, sel, waited;
    bit found;

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_val("rst_io_dout", io_dout, 0);
    chk_val("rst_din", din, 0);
    chk_val("rst_wr_an", wr_an, 0);
    chk_val("rst_wr_bn", wr_bn, 0);
    chk_val("rst_harmonic", harmonic, 0);
    chk_val("rst_waveform", waveform, 0);
    chk_val("rst_irq", irq, 0);

    wr_and_check('hA3, 'h5A, an, bn, dd);
    chk_val("a3_an", an, 9'h008);
    chk_val("a3_bn", bn, 9'h000);
    chk_val("a3_din", dd, 8'h5A);
    wr_and_check('hB8, 'h31, an, bn, dd);
    chk_val("b8_bn", bn, 9'h100);
    chk_val("b8_din", dd, 8'h31);
    wr_and_check('hB9, 'hFF, an, bn, dd);
    chk_val("b9_bn", bn, 9'h000);
    chk_val("b9_din_kept", dd, 8'h31);
    wr_and_check('h33, 'h07, an, bn, dd);
    chk_val("op15_mult", harmonic[63:60], 4'h7);
    wr_and_check('h26, 'h0F, an, bn, dd);
    chk_val("hole_26", harmonic, 72'h7 << 60);
    wr_and_check('hE0, 'h03, an, bn, dd);
    chk_val("wse0_op0", waveform, 36'h0);
    wr_and_check('h01, 'h20, an, bn, dd);
    chk_val("wse1_op0", waveform, 36'h3);
    wr_and_check('h01, 'h00, an, bn, dd);
    wr_and_check('h01, 'h20, an, bn, dd);
    chk_val("wse_retained", waveform, 36'h3);

    // Back-to-back data writes to the same channel.
    bus_wr(1'b0, 8'hA1);
    io_a0 = 1'b1; io_din = 8'h11; io_wr = 1'b1;
    @(negedge clk);
    chk_val("b2b_din1", din, 8'h11);
    chk_val("b2b_an1", wr_an, 9'h002);
    io_din = 8'h22;
    @(negedge clk);
    io_wr = 1'b0;
    chk_val("b2b_din2", din, 8'h22);
    chk_val("b2b_an2", wr_an, 9'h002);
    @(negedge clk);
    chk_val("b2b_an_end", wr_an, 9'h000);
    din_m = 'h22;

    // Read and write together: the write lands, the read returns status.
    io_rd = 1'b1;
    wr_and_check('hB2, 'h44, an, bn, dd);
    chk_val("rdwr_status", io_dout, 8'h00);
    io_rd = 1'b0;
    chk_val("rdwr_bn", bn, 9'h004);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: idx = 'hA0 + $urandom_range(0, 15);
        1: idx = 'hB0 + $urandom_range(0, 15);
        2: idx = 'h20 + $urandom_range(0, 31);
        3: idx = 'hE0 + $urandom_range(0, 31);
        4: idx = 'h01;
        default: idx = $urandom_range(0, 255);
      endcase
      if (idx >= 2 && idx <= 4) idx = 5;
      d = $urandom_range(0, 255);
      wr_and_check(idx, d, an, bn, dd);
    end

    // Reset coincident with a data write drops the strobe and clears everything.
    bus_wr(1'b0, 8'hA3);
    io_a0 = 1'b1; io_din = 8'h55; io_wr = 1'b1; rst = 1'b1;
    @(negedge clk);
    io_wr = 1'b0; rst = 1'b0;
    model_reset();
    chk_val("midrst_an", wr_an, 0);
    chk_val("midrst_din", din, 0);
    chk_val("midrst_harmonic", harmonic, 0);
    chk_val("midrst_waveform", waveform, 0);
    bus_wr(1'b1, 8'h77);
    chk_val("midrst_index0_an", wr_an, 0);
    chk_val("midrst_index0_din", din, 0);

`ifdef YM3812_TIMERS_EN
    do_reset();
    reg_wr(8'h02, 8'hFF);
    reg_wr(8'h04, 8'h01);
    found = 0;
    waited = 0;
    while (!found && waited < T1_PER + 10) begin
      @(negedge clk);
      waited++;
      if (io_dout != 8'h00) found = 1;
    end
    chk_val("t1_seen", found, 1);
    chk_val("t1_status", io_dout, 8'hC0);
    chk_val("t1_irq", irq, 1);
    reg_wr(8'h04, 8'h80);
    chk_val("clr_lag", io_dout, 8'hC0);
    @(negedge clk);
    chk_val("clr_status", io_dout, 8'h00);
    chk_val("clr_irq", irq, 0);

    do_reset();
    reg_wr(8'h03, 8'hFE);
    reg_wr(8'h04, 8'h42);
    found = 0;
    waited = 0;
    while (!found && waited < 2 * T2_PER + 10) begin
      @(negedge clk);
      waited++;
      if (io_dout != 8'h00) found = 1;
    end
    chk_val("t2_seen", found, 1);
    chk_val("t2_status", io_dout, 8'hA0);
    chk_val("t2_irq", irq, 1);
    chk_val("t2_not_early", waited >= T2_PER - 4, 1);

    do_reset();
    reg_wr(8'h03, 8'hFF);
    reg_wr(8'h04, 8'h42);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_val("t2_rst_status", io_dout, 8'h00);
    found = 0;
    repeat (T2_PER + 100) begin
      @(negedge clk);
      if (io_dout != 8'h00 || irq) found = 1;
    end
    chk_val("t2_rst_no_flag", found, 0);
`else
    reg_wr(8'h02, 8'hFF);
    reg_wr(8'h03, 8'hFF);
    reg_wr(8'h04, 8'h03);
    found = 0;
    repeat (T1_PER + 20) begin
      @(negedge clk);
      if (io_dout != 8'h00 || irq) found = 1;
    end
    chk_val("notimer_quiet", found, 0);
    chk_val("notimer_status", io_dout, 8'h00);
    chk_val("notimer_irq", irq, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ym3812_regs.md
# ym3812_regs

CPU-side register front end for the OPL2 (YM3812) sound block: the writer that drives the per-channel oscillator register strobes. Decodes the two AdLib I/O ports (index at A0=0, data at A0=1) and maintains the register file. Issues one-cycle F-number/block/key-on write strobes with a shared data byte to nine channel oscillators and holds per-operator multiplier and waveform fields. Also implements the two OPL2 timers, the status byte and the IRQ line used by AdLib detection code.

## Interface
- CLK_HZ, 75000000, system clock frequency; sets timer prescaler
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- io_a0  in  1  port select: 0 = index/status, 1 = data
- io_din  in  8  CPU write data
- io_wr  in  1  write strobe, one cycle per access
- io_rd  in  1  read strobe, one cycle per access
- io_dout  out  8  read data (status byte)
- din  out  8  data byte to channel oscillators
- wr_an  out  9  per-channel F-number-low write strobe (bit c = channel c)
- wr_bn  out  9  per-channel key-on/block/F-number-high write strobe
- harmonic  out  72  18 operators × 4-bit multiplier, operator k at [4k+3:4k]
- waveform  out  36  18 operators × 2-bit waveform, operator k at [2k+1:2k]
- irq  out  1  timer interrupt, active-high

## Operation
- Reset: index=0, all registers 0, din=0, wr_an=wr_bn=0, harmonic=0, waveform=0, io_dout=0, irq=0, timers stopped, flags clear.
- io_wr & !io_a0: index <= io_din. io_wr & io_a0: write io_din to register[index].
- 0xA0–0xA8: din <= value; wr_an[index-0xA0] pulses. 0xB0–0xB8: same via wr_bn. 0xA9–0xAF, 0xB9–0xBF: ignored, no strobe.
- Operator offset o = index & 0x1F for 0x20–0x35 (multiplier, bits[3:0]) and 0xE0–0xF5 (waveform, bits[1:0]). Offset→operator: o = 8·g + s, g∈0..2, s∈0..5 → operator k = 6·g + s. s=6,7 (offsets 0x06,0x07,0x0E,0x0F,0x16+) ignored. Channel c (c = 3·g + s, s<3) uses operator 6·g+s as modulator and 6·g+s+3 as carrier.
- 0x01 bit5 = WSE. waveform output for every operator = stored value if WSE=1, else 0; stored values retained while WSE=0.
- 0x02 = T1 preset, 0x03 = T2 preset.
- 0x04: bit7=1 → clear both flags, all other bits ignored. Else bit6 = T1 mask, bit5 = T2 mask, bit0 = T1 run, bit1 = T2 run.
- Timer run 0→1: counter loads preset. While running, each tick (T1: 80 µs = CLK_HZ/12500 clocks; T2: 320 µs, 4× T1 ticks) counter+1; at 0xFF next tick reloads preset and sets flag unless masked. Run 1→0: counter frozen, flag kept.
- Status = {irq, T1 flag, T2 flag, 5'b0}; irq = T1 flag | T2 flag.
- Other indices: accepted, no effect.

## Timing
- Data write in cycle N: strobe and din valid in cycle N+1, exactly one cycle; harmonic/waveform update at N+1.
- Back-to-back data writes: strobes in consecutive cycles, each with its own din.
- io_dout: registered status, updated every cycle; value at cycle N+1 reflects state at N. io_rd has no side effect.
- Flag set and bit7-clear write in same cycle: clear wins, overflow lost.
- Prescaler free-running from reset; first tick after start at 1..period clocks (≤1 tick jitter accepted).
- io_wr and io_rd simultaneous: write performed, read returns status.
- Reset mid-operation: everything returns to reset values next cycle; pending strobes dropped.

## Configuration
- YM3812_TIMERS_EN defined: timers, flags, status, irq as above.
- Undefined: no prescaler/counters; 0x02–0x04 ignored; io_dout=0x00 and irq=0 constantly.

## Test plan
- Write index 0xA3, data 0x5A → wr_an=9'h008 for one cycle with din=0x5A; wr_bn=0.
- Write 0xB8=0x31 → wr_bn=9'h100, din=0x31; write 0xB9=0xFF → no strobe.
- Write 0x33=0x07 → harmonic operator 15 (g=2,s=3) = 7; write 0x26=0x0F → no change anywhere.
- Write 0xE0=0x03 with WSE=0 → waveform op0=0; then 0x01=0x20 → op0=3.
- Timers: 0x02=0xFF, 0x04=0x01 → after 6000 clocks status=0xC0, irq=1; write 0x04=0x80 → status=0x00 next+1 cycle.
- T2: 0x03=0xFE, 0x04=0x42 → T1 masked, status=0xA0 after 2×24000 clocks; rst mid-count → status 0x00, no further flag.
